// File: rtl/uart_rx.sv
// UART receiver: oversamples rx, recovers NUM_WORDS frames and assembles them
// into one W_OUT-bit word presented on a valid/ready master port.
module uart_rx #(
    parameter int unsigned CLOCKS_PER_PULSE = 4,
    parameter int unsigned BITS_PER_WORD    = 8,
    parameter int unsigned PACKET_SIZE      = 13,
    parameter int unsigned W_OUT            = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    output logic [W_OUT-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int unsigned NUM_STOP  = PACKET_SIZE - BITS_PER_WORD - 1;
    localparam int unsigned HALF      = CLOCKS_PER_PULSE / 2;
    localparam int unsigned BIT_MAX   = (BITS_PER_WORD > NUM_STOP) ? BITS_PER_WORD : NUM_STOP;
    localparam int unsigned CNT_W     = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int unsigned BIT_W     = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE,
        DELIVER
    } state_t;

    state_t                   state, state_d;
    logic                     rx_meta, rx_s;
    logic [CNT_W-1:0]         cnt, cnt_d;
    logic [BIT_W-1:0]         bitcnt, bitcnt_d;
    logic [IDX_W-1:0]         idx, idx_d;
    logic [BITS_PER_WORD-1:0] shift, shift_d;
    logic [W_OUT-1:0]         packet, packet_d;
    logic [W_OUT-1:0]         m_data_d;
    logic                     m_valid_d, frame_err_d, overrun_d;

    // State and datapath registers, plus the 2-flop input synchronizer
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            cnt       <= '0;
            bitcnt    <= '0;
            idx       <= '0;
            shift     <= '0;
            packet    <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            cnt       <= cnt_d;
            bitcnt    <= bitcnt_d;
            idx       <= idx_d;
            shift     <= shift_d;
            packet    <= packet_d;
            m_data    <= m_data_d;
            m_valid   <= m_valid_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bitcnt_d    = bitcnt;
        idx_d       = idx;
        shift_d     = shift;
        packet_d    = packet;
        m_data_d    = m_data;
        m_valid_d   = m_valid && !m_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    if (!rx_s) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_W'(CLOCKS_PER_PULSE - 1)) begin
                    cnt_d           = '0;
                    shift_d[bitcnt] = rx_s;
                    if (bitcnt == BIT_W'(BITS_PER_WORD - 1)) begin
                        state_d  = STOP;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_W'(CLOCKS_PER_PULSE - 1)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                        state_d     = WAIT_IDLE;
                    end else if (bitcnt == BIT_W'(NUM_STOP - 1)) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            if (idx == IDX_W'(i)) packet_d[i*BITS_PER_WORD +: BITS_PER_WORD] = shift;
                        end
                        if (idx == IDX_W'(NUM_WORDS - 1)) begin
                            state_d = DELIVER;
                        end else begin
                            idx_d   = idx + IDX_W'(1);
                            state_d = IDLE;
                        end
                    end else begin
                        bitcnt_d = bitcnt + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            DELIVER: begin
                idx_d   = '0;
                state_d = IDLE;
                if (!m_valid || m_ready) begin
                    m_data_d  = packet;
                    m_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state entry restarts the baud counter
        if (state_d != state) cnt_d = '0;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are synthesised from the
// frame format rules and received words are compared against a queue.
module tb_uart_rx;

    localparam int unsigned C     = 4;
    localparam int unsigned B     = 8;
    localparam int unsigned P     = 13;
    localparam int unsigned W     = 16;
    localparam int unsigned NSTOP = P - B - 1;

    logic         clk = 1'b0;
    logic         rstn;
    logic         rx;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         frame_err;
    logic         overrun;

    int           checks   = 0;
    int           failures = 0;
    int           ferr_cnt = 0;
    int           ovr_cnt  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_word;

    uart_rx #(
        .CLOCKS_PER_PULSE(C),
        .BITS_PER_WORD   (B),
        .PACKET_SIZE     (P),
        .W_OUT           (W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (C) tick();
    endtask

    // One frame: start, data LSB first, stop/padding bits; bad_stop selects a forced-0 stop bit
    task automatic send_frame(input logic [B-1:0] b, input int bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < B; i++) send_bit(b[i]);
        for (int i = 0; i < NSTOP; i++) send_bit(i == bad_stop ? 1'b0 : 1'b1);
        rx = 1'b1;
    endtask

    task automatic send_packet(input logic [W-1:0] w, input int gap);
        send_frame(w[B-1:0], -1);
        repeat (gap) tick();
        send_frame(w[W-1:B], -1);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    // Monitor: every accepted beat must match the oldest expected word
    always @(negedge clk) begin
        if (rstn) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(exp_word));
                end
            end
        end
    end

    initial begin
        int ferr0, ovr0, n;
        logic [W-1:0] w;

        rstn    = 1'b0;
        rx      = 1'b1;
        m_ready = 1'b1;
        repeat (3) tick();
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        rstn = 1'b1;
        idle(5);

        // Basic back-to-back pair
        exp_q.push_back(16'h3CA5);
        send_packet(16'h3CA5, 0);
        idle(10);
        wait_drain();
        check("basic_ferr", 32'(ferr_cnt), 0);
        check("basic_ovr", 32'(ovr_cnt), 0);

        // Random packets with random gaps
        for (int k = 0; k < 10; k++) begin
            w = W'($urandom);
            exp_q.push_back(w);
            send_packet(w, int'($urandom_range(0, 8)));
            idle(int'($urandom_range(1, 20)));
        end
        wait_drain();
        check("rand_ferr", 32'(ferr_cnt), 0);
        check("rand_ovr", 32'(ovr_cnt), 0);

        // Back-pressure and overrun
        m_ready = 1'b0;
        ovr0 = ovr_cnt;
        send_packet(16'h1234, 2);
        idle(10);
        check("bp_valid", 32'(m_valid), 1);
        send_packet(16'hBEEF, 0);
        n = 0;
        while (ovr_cnt == ovr0 && n < 200) begin
            tick();
            n++;
        end
        idle(10);
        check("bp_overrun_cnt", 32'(ovr_cnt), 32'(ovr0 + 1));
        check("bp_hold_data", 32'(m_data), 32'h1234);
        check("bp_hold_valid", 32'(m_valid), 1);
        exp_q.push_back(16'h1234);
        m_ready = 1'b1;
        tick();
        tick();
        check("bp_valid_drop", 32'(m_valid), 0);
        check("bp_drained", 32'(exp_q.size()), 0);

        // Framing error on the 2nd stop bit of the second frame
        ferr0 = ferr_cnt;
        send_frame(8'h55, -1);
        send_frame(8'hAA, 1);
        idle(20);
        check("ferr_cnt", 32'(ferr_cnt), 32'(ferr0 + 1));
        check("ferr_no_valid", 32'(m_valid), 0);
        exp_q.push_back(16'h2211);
        send_packet(16'h2211, 0);
        idle(10);
        wait_drain();

        // One-cycle glitch is ignored
        ferr0 = ferr_cnt;
        rx = 1'b0;
        tick();
        idle(30);
        check("glitch_valid", 32'(m_valid), 0);
        check("glitch_ferr", 32'(ferr_cnt), 32'(ferr0));
        exp_q.push_back(16'hC3C3);
        send_packet(16'hC3C3, 1);
        idle(10);
        wait_drain();

        // Reset in the middle of the first word's data bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rstn = 1'b0;
        rx   = 1'b1;
        tick();
        tick();
        check("mid_rst_valid", 32'(m_valid), 0);
        check("mid_rst_data", 32'(m_data), 0);
        check("mid_rst_ferr", 32'(frame_err), 0);
        check("mid_rst_ovr", 32'(overrun), 0);
        rstn = 1'b1;
        idle(10);
        exp_q.push_back(16'h0F0F);
        send_packet(16'h0F0F, 0);
        idle(10);
        wait_drain();
        check("final_ovr", 32'(ovr_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
